// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the arbitrated output mux: arbitration mode encoding.
package rr_arb_mux_pkg;

  localparam int RR_MODE    = 1;
  localparam int FIXED_MODE = 0;

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Rotate-and-priority-encode: the first requester at or after base, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic [SW-1:0] gnt_idx,
  output logic          any_req
);

  logic [SW:0] idx;

  always_comb begin
    gnt_idx = '0;
    any_req = |req;
    idx     = '0;
    // Scan from farthest to nearest so the closest requester to base wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, base} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(N)) begin
        idx = idx - (SW + 1)'(N);
      end
      if (req[idx[SW-1:0]]) begin
        gnt_idx = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux with valid/ready inputs and a single registered output stage.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int RR = RR_MODE,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [SW-1:0] base;
  logic [SW-1:0] gnt_idx;
  logic          any_req;
  logic          load;
  logic          xfer;

  assign base = (RR == RR_MODE) ? ptr_q : '0;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req     (in_valid),
    .base    (base),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // The register can refill in the same cycle its current beat is consumed.
  assign load = ~out_valid_q | out_ready;
  assign xfer = load & any_req;

  always_comb begin
    in_ready = '0;
    if (!reset && xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*W +: W];
      out_sel_d   = gnt_idx;
      if (RR == RR_MODE) begin
        ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin instance tracked by a model/scoreboard, plus a fixed-priority instance.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  logic [N-1:0]   in_valid_f;
  logic [N-1:0]   in_ready_f;
  logic           out_valid_f;
  logic [W-1:0]   out_data_f;
  logic [1:0]     out_sel_f;
  logic           out_ready_f;

  int n_checks = 0;
  int n_errors = 0;

  rr_arb_mux #(.N(N), .W(W), .RR(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.N(N), .W(W), .RR(0)) dut_fix (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid_f),
    .in_data   (in_data),
    .in_ready  (in_ready_f),
    .out_valid (out_valid_f),
    .out_data  (out_data_f),
    .out_sel   (out_sel_f),
    .out_ready (out_ready_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference round-robin pick: first requester scanning base, base+1, ... mod 4.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Scoreboard for the round-robin instance: expected beats pushed when the
  // model predicts a handshake, popped when the beat appears on the output.
  logic [33:0] sb_q[$];
  logic [1:0]  mdl_ptr, mdl_sel, g_pend;
  logic        mdl_ov, xfer_pend, load_pend, beat_due;
  logic [31:0] mdl_data, d_pend;

  initial begin
    logic [33:0] e;
    logic        ld, any;
    logic [1:0]  g;
    logic [3:0]  exp_rdy;
    mdl_ptr = 0; mdl_sel = 0; mdl_data = 0; mdl_ov = 0;
    xfer_pend = 0; load_pend = 0; beat_due = 0; g_pend = 0; d_pend = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mdl_ptr = 0; mdl_ov = 0; mdl_data = 0; mdl_sel = 0; beat_due = 0;
        sb_q.delete();
      end else if (xfer_pend) begin
        mdl_ov   = 1'b1;
        mdl_sel  = g_pend;
        mdl_data = d_pend;
        mdl_ptr  = (g_pend == 2'd3) ? 2'd0 : g_pend + 2'd1;
        beat_due = 1'b1;
      end else if (load_pend) begin
        mdl_ov = 1'b0;
      end
      @(negedge clk);
      if (beat_due) begin
        beat_due = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_underflow: beat expected but scoreboard empty, out_sel=%0d", out_sel);
        end else begin
          e = sb_q.pop_front();
          if (out_sel !== e[33:32] || out_data !== e[31:0]) begin
            n_errors++;
            $display("FAIL sb_beat: got sel=%0d data=%h expected sel=%0d data=%h",
                     out_sel, out_data, e[33:32], e[31:0]);
          end
        end
      end
      n_checks++;
      if (out_valid !== mdl_ov || out_sel !== mdl_sel || out_data !== mdl_data) begin
        n_errors++;
        $display("FAIL mdl_out: got v=%b sel=%0d data=%h expected v=%b sel=%0d data=%h",
                 out_valid, out_sel, out_data, mdl_ov, mdl_sel, mdl_data);
      end
      ld  = !mdl_ov || out_ready;
      any = |in_valid;
      g   = pick(in_valid, mdl_ptr);
      exp_rdy = (!reset && ld && any) ? (4'b0001 << g) : 4'b0000;
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL mdl_in_ready: got %b expected %b", in_ready, exp_rdy);
      end
      xfer_pend = !reset && ld && any;
      load_pend = !reset && ld;
      g_pend    = g;
      d_pend    = in_data[int'(g)*W +: W];
      if (xfer_pend) sb_q.push_back({g, d_pend});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + 32'(i);
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 4'hF; out_ready = 1; set_data(32'h1000_0000);
    in_valid_f = 0; out_ready_f = 1;
    repeat (2) begin
      cyc();
      n_checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
        n_errors++;
        $display("FAIL reset_hold: got rdy=%b v=%b data=%h sel=%0d expected all zero",
                 in_ready, out_valid, out_data, out_sel);
      end
    end
    reset = 0;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_release_rdy: got %b expected 0001", in_ready);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'h1000_0000) begin
      n_errors++;
      $display("FAIL reset_first_xfer: got v=%b sel=%0d data=%h expected v=1 sel=0 data=10000000",
               out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_rr_all();
    reset = 1; in_valid = 4'hF; out_ready = 1;
    cyc();
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (in_ready !== (4'b0001 << (k % 4))) begin
        n_errors++;
        $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, 4'b0001 << (k % 4));
      end
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 32'h1000_0000 + 32'(k % 4)) begin
        n_errors++;
        $display("FAIL rr_seq[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d",
                 k, out_valid, out_sel, out_data, k % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    cyc();
    n_checks++;
    if (out_sel !== 2'd2) begin
      n_errors++;
      $display("FAIL bp_setup: got sel=%0d expected 2", out_sel);
    end
    out_ready = 0; in_valid = 4'b1011;
    in_data[2*W +: W] = 32'hDEAD_0002;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_errors++;
      $display("FAIL bp_rdy_enter: got %b expected 0000", in_ready);
    end
    repeat (3) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'h1000_0002 || in_ready !== 4'b0000) begin
        n_errors++;
        $display("FAIL bp_hold: got v=%b sel=%0d data=%h rdy=%b expected v=1 sel=2 data=10000002 rdy=0000",
                 out_valid, out_sel, out_data, in_ready);
      end
    end
    out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_errors++;
      $display("FAIL bp_release_rdy: got %b expected 1000", in_ready);
    end
    cyc();
    n_checks++;
    if (out_sel !== 2'd3 || out_data !== 32'h1000_0003) begin
      n_errors++;
      $display("FAIL bp_next_grant: got sel=%0d data=%h expected sel=3 data=10000003", out_sel, out_data);
    end
    set_data(32'h2000_0000);
  endtask

  task automatic test_wrap();
    logic [3:0] pat [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b1111};
    logic [1:0] exp [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      in_valid = pat[k];
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== exp[k] || out_data !== 32'h2000_0000 + 32'(exp[k])) begin
        n_errors++;
        $display("FAIL wrap[%0d]: got sel=%0d data=%h expected sel=%0d", k, out_sel, out_data, exp[k]);
      end
    end
  endtask

  task automatic test_drain();
    in_valid = 4'b0000;
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h2000_0000 || out_sel !== 2'd0) begin
      n_errors++;
      $display("FAIL drain: got v=%b sel=%0d data=%h expected v=0 sel=0 data=20000000",
               out_valid, out_sel, out_data);
    end
    repeat (2) cyc();
    in_valid = 4'hF;
    cyc();
    n_checks++;
    if (out_sel !== 2'd1) begin
      n_errors++;
      $display("FAIL idle_ptr_hold: got sel=%0d expected 1", out_sel);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b0100;
    cyc();
    out_ready = 0; in_valid = 4'b0000; reset = 1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pre: got rdy=%b v=%b expected rdy=0000 v=1", in_ready, out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      n_errors++;
      $display("FAIL rst_mid_drop: got v=%b sel=%0d data=%h expected all zero", out_valid, out_sel, out_data);
    end
    reset = 0; out_ready = 1; in_valid = 4'hF;
    cyc();
    n_checks++;
    if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_ptr: got sel=%0d v=%b expected sel=0 v=1", out_sel, out_valid);
    end
  endtask

  task automatic test_fixed();
    in_valid_f = 4'b0110; out_ready_f = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready_f !== 4'b0010) begin
        n_errors++;
        $display("FAIL fixed_rdy[%0d]: got %b expected 0010", k, in_ready_f);
      end
      cyc();
      n_checks++;
      if (out_valid_f !== 1'b1 || out_sel_f !== 2'd1 || out_data_f !== 32'h2000_0001) begin
        n_errors++;
        $display("FAIL fixed_sel[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=1 data=20000001",
                 k, out_valid_f, out_sel_f, out_data_f);
      end
    end
    in_valid_f = 4'b1100;
    cyc();
    n_checks++;
    if (out_sel_f !== 2'd2 || out_data_f !== 32'h2000_0002) begin
      n_errors++;
      $display("FAIL fixed_next: got sel=%0d data=%h expected sel=2 data=20000002", out_sel_f, out_data_f);
    end
    in_valid_f = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_backpressure();
    test_wrap();
    test_drain();
    test_reset_mid();
    test_fixed();
    in_valid = 4'b0000;
    repeat (3) cyc();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d pending beats expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
